// File: rtl/nes_ppu_pkg.sv
// Shared NES PPU constants, fetch-phase encodings and the fetch state type.
// Latency: n/a (declarations only).
// Backpressure: n/a; the pixel path is free-running and never stalls.
package nes_ppu_pkg;

  // NES picture size; the VGA path doubles both dimensions.
  localparam int NES_W = 256;
  localparam int NES_H = 240;

  // Attribute table sits right after the 960-byte name table.
  localparam logic [9:0] AT_BASE = 10'd960;

  // Fetch phase within a 16-clock tile slot (rel[3:0]).
  localparam logic [3:0] PH_NT   = 4'd0;
  localparam logic [3:0] PH_AT   = 4'd1;
  localparam logic [3:0] PH_PLO  = 4'd2;
  localparam logic [3:0] PH_PHI  = 4'd3;
  localparam logic [3:0] PH_LOAD = 4'd15;

  localparam int PAL_W = 5;
  typedef logic [PAL_W-1:0] pal_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NT,
    ST_AT,
    ST_PLO,
    ST_PHI,
    ST_WAIT,
    ST_LOAD
  } fetch_st_t;

endpackage

// File: rtl/nes_bg_pixel_gen_if.sv
// Bundle between the background pixel generator and its surroundings:
// beam position in, ROM address/data pairs, palette address out.
// Backpressure: none; every signal is valid every clock.
//   col/row   : VGA beam position from the sync generator
//   nt_*      : name-table/attribute ROM address and same-cycle data
//   pat_*     : pattern ROM address and same-cycle data
//   pal_*     : registered palette ROM address and window flag
interface nes_bg_pixel_gen_if;
  import nes_ppu_pkg::*;

  logic [9:0]  col;
  logic [9:0]  row;
  logic [9:0]  nt_addr;
  logic [7:0]  nt_data;
  logic [11:0] pat_addr;
  logic [7:0]  pat_data;
  pal_addr_t   pal_addr;
  logic        pal_vld;

  // Environment side: sync generator, ROMs, palette lookup.
  modport master (
    output col, row, nt_data, pat_data,
    input  nt_addr, pat_addr, pal_addr, pal_vld
  );

  // Pixel generator side.
  modport slave (
    input  col, row, nt_data, pat_data,
    output nt_addr, pat_addr, pal_addr, pal_vld
  );
endinterface

// File: rtl/nes_attr_sel.sv
// Picks the 2-bit palette group of one 16x16-pixel quadrant from an attribute byte.
// Latency: combinational.
// Backpressure: none.
//   attr_byte : attribute byte (4 quadrants, 2 bits each)
//   ty1, t1   : bit 1 of tile row / tile column (selects bottom / right quadrant)
//   quad      : selected 2-bit palette group
module nes_attr_sel (
  input  logic [7:0] attr_byte,
  input  logic       ty1,
  input  logic       t1,
  output logic [1:0] quad
);

  always_comb begin
    quad = attr_byte[1:0];
    unique case ({ty1, t1})
      2'b00: quad = attr_byte[1:0];
      2'b01: quad = attr_byte[3:2];
      2'b10: quad = attr_byte[5:4];
      2'b11: quad = attr_byte[7:6];
    endcase
  end

endmodule

// File: rtl/nes_bg_pixel_gen.sv
// NES background pixel generator: fetches tiles one slot ahead of the beam, outputs palette addresses.
// Latency: 1 clock from col/row to pal_addr/pal_vld; ROM addresses are combinational from col/row.
// Backpressure: none; runs every pixel clock, hsync/vsync are delayed 1 clock externally to match.
//   clk, rst : pixel clock, async active-high reset
//   bus      : slave side of nes_bg_pixel_gen_if (col,row,nt_*,pat_*,pal_*)
module nes_bg_pixel_gen
  import nes_ppu_pkg::*;
#(
  parameter int H_OFS = 64,
  parameter int V_OFS = 0
) (
  input  logic                clk,
  input  logic                rst,
  nes_bg_pixel_gen_if.slave   bus
);

  // Column relative to the start of the fetch window (one tile before the picture).
  logic [9:0] rel;
  logic [9:0] vrow;
  logic       vwin;
  logic       fwin;
  logic       dwin;
  logic [4:0] t;
  logic [3:0] ph;
  logic [7:0] ny;
  logic [4:0] ty;
  logic [2:0] fy;

  assign rel  = bus.col - 10'(H_OFS - 16);
  assign vrow = bus.row - 10'(V_OFS);
  assign vwin = (bus.row >= 10'(V_OFS)) && (vrow < 10'(2 * NES_H));
  assign fwin = vwin && (rel < 10'(2 * NES_W));
  assign dwin = vwin && (rel >= 10'd16) && (rel < 10'(2 * NES_W + 16));

  assign t  = rel[8:4];
  assign ph = rel[3:0];
  assign ny = vrow[8:1];  // each NES line is shown on two VGA rows
  assign ty = ny[7:3];
  assign fy = ny[2:0];

  // Fetch latches (tile being fetched) and display registers (tile on screen).
  logic [7:0] tile_r, lo_r, hi_r;
  logic [1:0] attr_r;
  logic [7:0] lo_d, hi_d;
  logic [1:0] attr_d;
  logic [1:0] attr_q;

  nes_attr_sel u_attr_sel (
    .attr_byte (bus.nt_data),
    .ty1       (ty[1]),
    .t1        (t[1]),
    .quad      (attr_q)
  );

  // The fetch phase is a pure function of the column, so the state is decoded
  // every cycle rather than stored; a row change therefore needs no flush.
  fetch_st_t st;

  always_comb begin
    st           = ST_IDLE;
    bus.nt_addr  = '0;
    bus.pat_addr = '0;
    if (!rst && fwin) begin
      unique case (ph)
        PH_NT:   st = ST_NT;
        PH_AT:   st = ST_AT;
        PH_PLO:  st = ST_PLO;
        PH_PHI:  st = ST_PHI;
        PH_LOAD: st = ST_LOAD;
        default: st = ST_WAIT;
      endcase
    end
    unique case (st)
      ST_NT:   bus.nt_addr  = {ty, t};
      ST_AT:   bus.nt_addr  = AT_BASE + {4'd0, ty[4:2], t[4:2]};
      ST_PLO:  bus.pat_addr = {tile_r, 1'b0, fy};
      ST_PHI:  bus.pat_addr = {tile_r, 1'b1, fy};
      default: ;
    endcase
  end

  // Pixel select: each NES pixel spans two clocks, MSB of the pattern first.
  logic [2:0] b;
  logic [1:0] pix;
  pal_addr_t  pal_next;

  assign b   = 3'd7 - rel[3:1];
  assign pix = {hi_d[b], lo_d[b]};

  always_comb begin
    pal_next = '0;
    if (dwin && (pix != 2'd0)) pal_next = {1'b0, attr_d, pix};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_r       <= '0;
      attr_r       <= '0;
      lo_r         <= '0;
      hi_r         <= '0;
      attr_d       <= '0;
      lo_d         <= '0;
      hi_d         <= '0;
      bus.pal_addr <= '0;
      bus.pal_vld  <= 1'b0;
    end else begin
      unique case (st)
        ST_NT:   tile_r <= bus.nt_data;
        ST_AT:   attr_r <= attr_q;
        ST_PLO:  lo_r   <= bus.pat_data;
        ST_PHI:  hi_r   <= bus.pat_data;
        // Last clock of a slot: the fetched tile becomes visible on the next clock.
        ST_LOAD: begin
          attr_d <= attr_r;
          hi_d   <= hi_r;
          lo_d   <= lo_r;
        end
        default: ;
      endcase
      bus.pal_addr <= pal_next;
      bus.pal_vld  <= dwin;
    end
  end

endmodule

// File: tb/tb_nes_bg_pixel_gen.sv
// Self-checking bench for nes_bg_pixel_gen with behavioural ROM/picture model.
module tb_nes_bg_pixel_gen;

  localparam int H_OFS = 64;
  localparam int V_OFS = 0;
  localparam int FETCH0 = H_OFS - 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nes_bg_pixel_gen_if bus ();

  nes_bg_pixel_gen #(.H_OFS(H_OFS), .V_OFS(V_OFS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] nt_mem  [1024];
  logic [7:0] pat_mem [4096];

  assign bus.nt_data  = nt_mem[bus.nt_addr];
  assign bus.pat_data = pat_mem[bus.pat_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (col %0d row %0d)", name, act, exp, bus.col, bus.row);
    end
  endtask

  // Picture model: what the palette address must be for beam position (c, r).
  task automatic mdl_pix(input int c, input int r, output int vld, output int pal);
    int rel, x, tile, bi, ny, ty, fy, id, ab, at, lo, hi, p;
    rel = (c - FETCH0) & 1023;
    vld = 0;
    pal = 0;
    if (r >= V_OFS && r < V_OFS + 480 && rel >= 16 && rel < 528) begin
      vld  = 1;
      x    = (rel - 16) / 2;
      tile = x / 8;
      bi   = 7 - (x % 8);
      ny   = (r - V_OFS) / 2;
      ty   = ny / 8;
      fy   = ny % 8;
      id   = nt_mem[ty * 32 + tile];
      ab   = nt_mem[960 + (ty / 4) * 8 + tile / 4];
      at   = (ab >> (((ty / 2) % 2) * 4 + ((tile / 2) % 2) * 2)) % 4;
      lo   = pat_mem[id * 16 + fy];
      hi   = pat_mem[id * 16 + 8 + fy];
      p    = ((hi >> bi) % 2) * 2 + ((lo >> bi) % 2);
      pal  = (p == 0) ? 0 : at * 4 + p;
    end
  endtask

  // Fetch model: ROM addresses the generator must present at (c, r).
  task automatic mdl_fetch(input int c, input int r, output int nta, output int pta);
    int rel, ph, t, ny, ty, fy, id;
    rel = (c - FETCH0) & 1023;
    nta = 0;
    pta = 0;
    if (r >= V_OFS && r < V_OFS + 480 && rel < 512) begin
      ph = rel % 16;
      t  = rel / 16;
      ny = (r - V_OFS) / 2;
      ty = ny / 8;
      fy = ny % 8;
      id = nt_mem[ty * 32 + t];
      case (ph)
        0: nta = ty * 32 + t;
        1: nta = 960 + (ty / 4) * 8 + t / 4;
        2: pta = id * 16 + fy;
        3: pta = id * 16 + 8 + fy;
        default: ;
      endcase
    end
  endtask

  // Compare process state and per-line captures (indexed by column).
  bit chk_en  = 0;
  bit data_ok = 0;   // fetch pipeline primed from a clean line start
  int prev_col = 0;
  int prev_row = 0;
  bit prev_rst = 1;
  int cap_vld [800];
  int cap_pal [800];
  int cap_nt  [800];
  int cap_pat [800];

  always @(negedge clk) begin
    int ev, ea, en, ep;
    if (chk_en && !rst && !prev_rst) begin
      mdl_pix(prev_col, prev_row, ev, ea);
      chk("pal_vld", int'(bus.pal_vld), ev);
      if (data_ok || ev == 0) chk("pal_addr", int'(bus.pal_addr), ea);
      mdl_fetch(int'(bus.col), int'(bus.row), en, ep);
      chk("nt_addr", int'(bus.nt_addr), en);
      chk("pat_addr", int'(bus.pat_addr), ep);
    end
    if (prev_col < 800) begin
      cap_vld[prev_col] = int'(bus.pal_vld);
      cap_pal[prev_col] = int'(bus.pal_addr);
    end
    if (bus.col < 10'd800) begin
      cap_nt[bus.col]  = int'(bus.nt_addr);
      cap_pat[bus.col] = int'(bus.pat_addr);
    end
    prev_col = int'(bus.col);
    prev_row = int'(bus.row);
    prev_rst = rst;
  end

  task automatic step(input int c, input int r);
    @(posedge clk);
    #1;
    bus.col = 10'(c);
    bus.row = 10'(r);
  endtask

  task automatic run_line(input int r);
    data_ok = 1;
    for (int c = 0; c < 800; c++) step(c, r);
  endtask

  task automatic fill_scene(input int tile, input int lo, input int hi, input int ab);
    for (int i = 0; i < 960; i++) nt_mem[i] = 8'(tile);
    for (int i = 960; i < 1024; i++) nt_mem[i] = 8'(ab);
    for (int f = 0; f < 8; f++) begin
      pat_mem[tile * 16 + f]     = 8'(lo);
      pat_mem[tile * 16 + 8 + f] = 8'(hi);
    end
  endtask

  initial begin
    int nvld;
    for (int i = 0; i < 1024; i++) nt_mem[i] = 8'h00;
    for (int i = 0; i < 4096; i++) pat_mem[i] = 8'h00;
    bus.col = 10'd0;
    bus.row = 10'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pal_addr", int'(bus.pal_addr), 0);
    chk("rst_pal_vld", int'(bus.pal_vld), 0);
    chk("rst_nt_addr", int'(bus.nt_addr), 0);
    chk("rst_pat_addr", int'(bus.pat_addr), 0);
    bus.col = 10'd799;
    rst = 1'b0;
    chk_en = 1;

    // Solid colour 1 across the whole window.
    fill_scene(8'h24, 8'hFF, 8'h00, 8'h00);
    run_line(0);
    chk("a_vld_c63", cap_vld[63], 0);
    chk("a_vld_c64", cap_vld[64], 1);
    chk("a_pal_c64", cap_pal[64], 5'h01);
    chk("a_pal_c575", cap_pal[575], 5'h01);
    chk("a_vld_c575", cap_vld[575], 1);
    chk("a_vld_c576", cap_vld[576], 0);

    // Attribute quadrants with pixel value 3.
    fill_scene(8'h24, 8'hFF, 8'hFF, 8'h00);
    nt_mem[960] = 8'hE4;
    run_line(0);
    chk("at_ty0_t0", cap_pal[64], 5'h03);
    chk("at_ty0_t1", cap_pal[80], 5'h03);
    chk("at_ty0_t2", cap_pal[96], 5'h07);
    run_line(32);
    chk("at_ty2_t0", cap_pal[64], 5'h0B);
    chk("at_ty2_t2", cap_pal[96], 5'h0F);

    // Alternating pattern, attribute group 2.
    fill_scene(8'h24, 8'hAA, 8'h00, 8'h00);
    nt_mem[960] = 8'h02;
    run_line(0);
    chk("alt_c64", cap_pal[64], 5'h09);
    chk("alt_c65", cap_pal[65], 5'h09);
    chk("alt_c66", cap_pal[66], 5'h00);
    chk("alt_c67", cap_pal[67], 5'h00);

    // Fine row inside a tile.
    run_line(6);
    chk("fy3_nt", cap_nt[48], 0);
    chk("fy3_at", cap_nt[49], 960);
    chk("fy3_plo", cap_pat[50], 12'h243);
    chk("fy3_phi", cap_pat[51], 12'h24B);

    // Below the picture: nothing fetched, nothing shown.
    run_line(481);
    nvld = 0;
    for (int c = 0; c < 800; c++) nvld += cap_vld[c];
    chk("r481_vld_cnt", nvld, 0);
    chk("r481_nt", cap_nt[48], 0);
    chk("r481_pat", cap_pat[50], 0);

    // Reset in the middle of a displayed line.
    fill_scene(8'h24, 8'hFF, 8'h00, 8'h00);
    data_ok = 1;
    for (int c = 0; c <= 200; c++) step(c, 0);
    #1;
    chk("pre_rst_pal", int'(bus.pal_addr), 5'h01);
    data_ok = 0;
    rst = 1'b1;
    #1;
    chk("mid_rst_pal_addr", int'(bus.pal_addr), 0);
    chk("mid_rst_pal_vld", int'(bus.pal_vld), 0);
    chk("mid_rst_nt_addr", int'(bus.nt_addr), 0);
    for (int c = 201; c <= 205; c++) step(c, 0);
    step(206, 0);
    rst = 1'b0;
    for (int c = 207; c < 800; c++) step(c, 0);
    run_line(16);
    chk("post_rst_nt", cap_nt[48], 32);
    chk("post_rst_pal", cap_pal[64], 5'h01);

    // Varied content, checked by the model on every cycle.
    for (int i = 0; i < 1024; i++) nt_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4096; i++) pat_mem[i] = 8'($urandom_range(0, 255));
    run_line(0);
    run_line(1);
    run_line(2);
    run_line(101);
    run_line(250);
    run_line(479);
    run_line(480);

    step(0, 0);
    step(1, 0);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
